layer_argmax: RTL
=================

# layer_argmax

Output classifier stage for the fully connected network. It sits directly downstream of the final matrix-multiply layer, which produces the 10 output activations. On `start` it snapshots the activation vector and scans it sequentially, one element per cycle. It then reports the index and value of the largest activation, plus a confidence flag, with a one-cycle `done` pulse. The result is held stable until the next classification completes.

## Interface
- `dataWidth`, default 8: width of each activation, unsigned.
- `NsInLayer`, default 10: number of activations (classes) scanned; must be ≥ 1.
- `confThreshold`, default 8'd128: `confident` asserts when the winning value is ≥ this threshold. Its width is `dataWidth`.
- `idxWidth`, default `$clog2(NsInLayer)` (minimum 1): width of the class index.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request classification of `inputActivation`; sampled only in IDLE.
- `inputActivation`, input, `dataWidth` × [NsInLayer-1:0]: unpacked array from the upstream layer; sampled in the cycle `start` is accepted.
- `busy`, output, 1: high in the SCAN and DONE states.
- `done`, output, 1: one-cycle pulse; result outputs are valid from this cycle on.
- `classIndex`, output, `idxWidth`: index of the maximum activation.
- `maxValue`, output, `dataWidth`: value of the maximum activation.
- `confident`, output, 1: `maxValue >= confThreshold`, registered together with the result.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE with `start`=1:
  - Copy the whole `inputActivation` into a snapshot register array.
  - Load `bestVal` with `inputActivation[0]` and `bestIdx` with 0.
  - Load `ptr` with 1.
  - Go to SCAN, or straight to DONE when `NsInLayer`=1.
- IDLE with `start`=0: stay in IDLE; nothing changes.
- SCAN, each cycle:
  - If `snap[ptr] > bestVal` (strictly greater, unsigned), load `bestVal` with `snap[ptr]` and `bestIdx` with `ptr`.
  - If `ptr == NsInLayer-1`, go to DONE; otherwise increment `ptr`.
- DONE, for one cycle:
  - Assert `done`.
  - The result registers hold the final values: `classIndex` = `bestIdx`, `maxValue` = `bestVal`, `confident` = (`bestVal` >= `confThreshold`).
  - Return to IDLE.
- Result registers load only on the transition into DONE. They hold their values through IDLE and through later scans until the next DONE.
- Ties: the lowest index wins, because the comparison is strict.
- `start` asserted while `busy`=1 is ignored and is not queued. `inputActivation` changing after acceptance has no effect on the result.
- `ptr` never exceeds `NsInLayer-1`; there is no wrap-around.
- The compare is a plain `dataWidth`-bit unsigned comparison; there is no arithmetic growth.

## Timing
- `start` is accepted at cycle 0. For N = `NsInLayer`:
  - SCAN occupies cycles 1 … N-1.
  - `done` is high in cycle N.
  - The earliest next `start` acceptance is cycle N+1.
- For N = 10, `done` is at cycle 10 and throughput is one classification per 11 cycles.
- Reset values: state IDLE; `busy`=0; `done`=0; `classIndex`=0; `maxValue`=0; `confident`=0. The snapshot array, `bestVal`, `bestIdx` and `ptr` also reset to 0.
- `rst` has priority over everything.
- `rst` during SCAN or DONE aborts the classification: no `done` pulse, outputs go to their reset values, and the next cycle is IDLE.
- `start` and `rst` high together: reset wins and `start` is dropped.
- `busy` is registered and goes high in cycle 1 after acceptance. It goes low in cycle N+1.
- All outputs are driven directly from registers.

## Test plan
- Distinct maximum:
  - Stimulus: reset; vector {3,7,1,200,5,9,0,4,2,6}; `start` at cycle 0.
  - Required: `done` exactly at cycle 10 and only there; `classIndex`=3; `maxValue`=200; `confident`=1; `busy` high cycles 1–10.
- Ties and boundary positions:
  - Stimulus: all ten values 50.
  - Required: `classIndex`=0, `maxValue`=50, `confident`=0.
  - Stimulus: max 255 at index 9 only.
  - Required: `classIndex`=9.
  - Stimulus: max at index 0 only.
  - Required: `classIndex`=0.
- Threshold edge:
  - Stimulus: max value 127.
  - Required: `confident`=0.
  - Stimulus: max value 128.
  - Required: `confident`=1.
  - Stimulus: all-zero vector.
  - Required: `classIndex`=0, `maxValue`=0.
- Snapshot isolation and busy rejection:
  - Stimulus: change `inputActivation` to an all-255 vector at cycle 2; pulse `start` at cycle 5.
  - Required: result matches the original vector; only one `done`.
  - Stimulus: next `start` at cycle 11.
  - Required: accepted; `done` at cycle 21.
- Reset mid-scan:
  - Stimulus: assert `rst` at cycle 4 of a scan.
  - Required: no `done`; all outputs 0 in the following cycle; a fresh `start` afterwards completes normally with `done` 10 cycles later.
- Result hold:
  - Stimulus: after a completed classification, idle for 20 cycles.
  - Required: `classIndex`, `maxValue` and `confident` unchanged, `done` low.
  - Stimulus: `NsInLayer`=1 instance with vector {77}.
  - Required: `done` at cycle 1; `classIndex`=0; `maxValue`=77.

Source files
------------

// File: rtl/layer_argmax.sv
// ---------------------------------------------------------------------------
// layer_argmax
//
// Output classifier stage. On an accepted start the activation vector is
// copied into a snapshot, then scanned one element per cycle to find the
// largest value. Index, value and a confidence flag are published with a
// one-cycle done pulse and held until the next classification completes.
//
// Ports
//   clk             : rising-edge clock
//   rst             : synchronous active-high reset, highest priority
//   start           : classification request, sampled only in IDLE
//   inputActivation : NsInLayer activations of dataWidth bits, unsigned
//   busy            : high while scanning and during the done cycle
//   done            : one-cycle pulse, results valid from this cycle on
//   classIndex      : index of the maximum activation (lowest index on ties)
//   maxValue        : value of the maximum activation
//   confident       : maxValue >= confThreshold
//   dbgState        : current FSM state encoding (observation only)
//
// Handshake: start is a single-cycle request qualified only by the FSM being
// in IDLE; any start seen while busy is high is dropped, never queued.
// ---------------------------------------------------------------------------
module layer_argmax #(
  parameter int                   dataWidth     = 8,
  parameter int                   NsInLayer     = 10,
  parameter logic [dataWidth-1:0] confThreshold = dataWidth'(128),
  parameter int                   idxWidth      = (NsInLayer > 1) ? $clog2(NsInLayer) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [dataWidth-1:0] inputActivation [NsInLayer-1:0],
  output logic                 busy,
  output logic                 done,
  output logic [idxWidth-1:0]  classIndex,
  output logic [dataWidth-1:0] maxValue,
  output logic                 confident,
  output logic [1:0]           dbgState
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [dataWidth-1:0] r_snap [NsInLayer-1:0];
  logic [dataWidth-1:0] r_best_val;
  logic [idxWidth-1:0]  r_best_idx;
  logic [idxWidth-1:0]  r_ptr;

  logic                 r_busy;
  logic                 r_done;
  logic [idxWidth-1:0]  r_class_index;
  logic [dataWidth-1:0] r_max_value;
  logic                 r_confident;

  logic [dataWidth-1:0] w_sel_val;
  logic                 w_last;
  logic [dataWidth-1:0] w_scan_val;
  logic [idxWidth-1:0]  w_scan_idx;
  logic [dataWidth-1:0] w_fin_val;
  logic [idxWidth-1:0]  w_fin_idx;
  logic                 w_enter_done;

  // Pointer start value; a single-element layer never scans, so it stays 0.
  localparam logic [idxWidth-1:0] PtrInit = (NsInLayer > 1) ? idxWidth'(1) : '0;

  // Snapshot element selected by ptr. Written as a compare-per-element mux so
  // the index width never has to match the array depth exactly.
  always_comb begin
    w_sel_val = '0;
    for (int i = 0; i < NsInLayer; i++) begin
      if (r_ptr == idxWidth'(i)) begin
        w_sel_val = r_snap[i];
      end
    end
  end

  assign w_last = (r_ptr == idxWidth'(NsInLayer - 1));

  // Strict compare keeps the earliest index on ties.
  always_comb begin
    w_scan_val = r_best_val;
    w_scan_idx = r_best_idx;
    if (w_sel_val > r_best_val) begin
      w_scan_val = w_sel_val;
      w_scan_idx = r_ptr;
    end
  end

  // Next-state and the values that the result registers capture on DONE entry.
  always_comb begin
    w_state_next = r_state;
    w_fin_val    = r_best_val;
    w_fin_idx    = r_best_idx;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = (NsInLayer == 1) ? S_DONE : S_SCAN;
          // Only used when the layer has one element and skips SCAN.
          w_fin_val    = inputActivation[0];
          w_fin_idx    = '0;
        end
      end
      S_SCAN: begin
        w_fin_val = w_scan_val;
        w_fin_idx = w_scan_idx;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign w_enter_done = (w_state_next == S_DONE) && (r_state != S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      for (int i = 0; i < NsInLayer; i++) begin
        r_snap[i] <= '0;
      end
      r_best_val    <= '0;
      r_best_idx    <= '0;
      r_ptr         <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_class_index <= '0;
      r_max_value   <= '0;
      r_confident   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != S_IDLE);
      r_done  <= w_enter_done;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            for (int i = 0; i < NsInLayer; i++) begin
              r_snap[i] <= inputActivation[i];
            end
            r_best_val <= inputActivation[0];
            r_best_idx <= '0;
            r_ptr      <= PtrInit;
          end
        end
        S_SCAN: begin
          r_best_val <= w_scan_val;
          r_best_idx <= w_scan_idx;
          if (!w_last) begin
            r_ptr <= r_ptr + idxWidth'(1);
          end
        end
        default: begin
        end
      endcase

      // Published results change only here and are held otherwise.
      if (w_enter_done) begin
        r_class_index <= w_fin_idx;
        r_max_value   <= w_fin_val;
        r_confident   <= (w_fin_val >= confThreshold);
      end
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign classIndex = r_class_index;
  assign maxValue   = r_max_value;
  assign confident  = r_confident;
  assign dbgState   = r_state;

endmodule
